// File: rtl/apb_master_ctrl.sv
// APB master controller: turns level read/write requests into single APB3
// transfers. It aborts with an error if PREADY stays low too long.
`ifndef APB_AW
`define APB_AW 32
`endif
`ifndef APB_DW
`define APB_DW 32
`endif
`ifndef APB_SLAVES
`define APB_SLAVES 2
`endif

module apb_master_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   m_apb_pclk_i,
  input  logic                   m_apb_preset_i,
  input  logic [`APB_AW-1:0]     read_write_addr_i,
  input  logic [`APB_SLAVES-1:0] read_write_sel_i,
  input  logic                   write_en_i,
  input  logic [`APB_DW-1:0]     write_data_i,
  input  logic                   read_en_i,
  output logic [`APB_DW-1:0]     read_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [`APB_AW-1:0]     m_apb_paddr_o,
  output logic [`APB_SLAVES-1:0] m_apb_psel_o,
  output logic                   m_apb_penable_o,
  output logic                   m_apb_pwrite_o,
  output logic [`APB_DW-1:0]     m_apb_pwdata_o,
  input  logic [`APB_DW-1:0]     m_apb_prdata_i,
  input  logic                   m_apb_pready_i,
  input  logic                   m_apb_pslverr_i
);

  // state  | meaning
  // IDLE   | no transfer; psel/penable low, waits for an armed request
  // SETUP  | first APB phase, psel high, penable low, exactly one cycle
  // ACCESS | penable high, waiting for pready or the timeout
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic                   armed;
  logic [7:0]             wait_cnt;
  logic                   req_any;
  logic                   accept;
  logic [`APB_SLAVES-1:0] sel_low;

  assign req_any = write_en_i | read_en_i;
  assign accept  = (state == IDLE) && armed && req_any && (|read_write_sel_i);
  // Isolate the lowest set bit so PSEL stays one-hot for any select pattern.
  assign sel_low = read_write_sel_i & (-read_write_sel_i);

  always_ff @(posedge m_apb_pclk_i) begin
    if (m_apb_preset_i) begin
      state           <= IDLE;
      armed           <= 1'b1;
      wait_cnt        <= 8'd0;
      read_data_o     <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      m_apb_paddr_o   <= '0;
      m_apb_psel_o    <= '0;
      m_apb_penable_o <= 1'b0;
      m_apb_pwrite_o  <= 1'b0;
      m_apb_pwdata_o  <= '0;
    end else begin
      done_o <= 1'b0;
      // Re-arm only after both enables were seen low; acceptance below wins.
      if (!req_any) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= SETUP;
            armed          <= 1'b0;
            busy_o         <= 1'b1;
            m_apb_paddr_o  <= read_write_addr_i;
            m_apb_pwdata_o <= write_data_i;
            m_apb_pwrite_o <= write_en_i;
            m_apb_psel_o   <= sel_low;
          end
        end
        SETUP: begin
          state           <= ACCESS;
          m_apb_penable_o <= 1'b1;
          wait_cnt        <= 8'd0;
        end
        ACCESS: begin
          if (m_apb_pready_i) begin
            state           <= IDLE;
            busy_o          <= 1'b0;
            done_o          <= 1'b1;
            error_o         <= m_apb_pslverr_i;
            m_apb_psel_o    <= '0;
            m_apb_penable_o <= 1'b0;
            if (!m_apb_pwrite_o) read_data_o <= m_apb_prdata_i;
          end else if (wait_cnt == WAIT_LAST) begin
            state           <= IDLE;
            busy_o          <= 1'b0;
            done_o          <= 1'b1;
            error_o         <= 1'b1;
            read_data_o     <= '0;
            m_apb_psel_o    <= '0;
            m_apb_penable_o <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed scenarios with literal expectations plus
// random traffic checked every cycle against a transaction-level model.
`ifndef APB_AW
`define APB_AW 32
`endif
`ifndef APB_DW
`define APB_DW 32
`endif
`ifndef APB_SLAVES
`define APB_SLAVES 2
`endif

module tb_apb_master_ctrl;
  localparam int TMO = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [`APB_AW-1:0]     addr = '0;
  logic [`APB_SLAVES-1:0] sel = '0;
  logic                   we = 1'b0;
  logic                   re = 1'b0;
  logic [`APB_DW-1:0]     wdata = '0;
  logic [`APB_DW-1:0]     prdata = '0;
  logic                   pready = 1'b0;
  logic                   pslverr = 1'b0;

  logic [`APB_DW-1:0]     read_data;
  logic                   busy, done, error;
  logic [`APB_AW-1:0]     paddr;
  logic [`APB_SLAVES-1:0] psel;
  logic                   penable, pwrite;
  logic [`APB_DW-1:0]     pwdata;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .m_apb_pclk_i(clk), .m_apb_preset_i(rst),
    .read_write_addr_i(addr), .read_write_sel_i(sel),
    .write_en_i(we), .write_data_i(wdata), .read_en_i(re),
    .read_data_o(read_data), .busy_o(busy), .done_o(done), .error_o(error),
    .m_apb_paddr_o(paddr), .m_apb_psel_o(psel), .m_apb_penable_o(penable),
    .m_apb_pwrite_o(pwrite), .m_apb_pwdata_o(pwdata),
    .m_apb_prdata_i(prdata), .m_apb_pready_i(pready), .m_apb_pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model. phase: 0 no transfer, 1 setup cycle, 2 access.
  bit                     m_valid = 0;
  int                     m_phase = 0;
  int                     m_acc   = 0;
  bit                     m_armed = 1;
  logic [`APB_AW-1:0]     e_paddr = '0;
  logic [`APB_SLAVES-1:0] e_psel = '0, e_tgt = '0;
  logic                   e_penable = 0, e_pwrite = 0, e_busy = 0, e_done = 0, e_error = 0;
  logic [`APB_DW-1:0]     e_pwdata = '0, e_rdata = '0;

  function automatic logic [`APB_SLAVES-1:0] lowest_bit(input logic [`APB_SLAVES-1:0] s);
    for (int i = 0; i < `APB_SLAVES; i++)
      if (s[i]) return `APB_SLAVES'(1) << i;
    return '0;
  endfunction

  always @(posedge clk) begin
    bit took;
    took = 0;
    if (rst) begin
      m_valid = 1; m_phase = 0; m_acc = 0; m_armed = 1;
      e_paddr = '0; e_psel = '0; e_tgt = '0; e_penable = 0; e_pwrite = 0;
      e_pwdata = '0; e_rdata = '0; e_busy = 0; e_done = 0; e_error = 0;
    end else begin
      e_done = 0;
      if (m_phase == 0) begin
        if (m_armed && (we || re) && sel != 0) begin
          took = 1;
          e_paddr = addr; e_pwdata = wdata; e_pwrite = we;
          e_tgt = lowest_bit(sel);
          e_psel = e_tgt; e_busy = 1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2; m_acc = 0; e_penable = 1;
      end else begin
        m_acc++;
        if (pready || m_acc == TMO) begin
          m_phase = 0; e_psel = '0; e_penable = 0; e_busy = 0; e_done = 1;
          if (pready) begin
            e_error = pslverr;
            if (!e_pwrite) e_rdata = prdata;
          end else begin
            e_error = 1; e_rdata = '0;
          end
        end
      end
      if (took) m_armed = 0;
      else if (!we && !re) m_armed = 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("psel", 64'(psel), 64'(e_psel));
      chk("penable", 64'(penable), 64'(e_penable));
      chk("paddr", 64'(paddr), 64'(e_paddr));
      chk("pwrite", 64'(pwrite), 64'(e_pwrite));
      chk("pwdata", 64'(pwdata), 64'(e_pwdata));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("read_data", 64'(read_data), 64'(e_rdata));
      if (e_done) chk("error", 64'(error), 64'(e_error));
    end
  end

  // Directed transfer with a simple slave: pready rises after 'waits' ACCESS cycles.
  task automatic run_xfer(input logic [`APB_AW-1:0] a, input logic [`APB_SLAVES-1:0] s,
                          input logic w, input logic r, input logic [`APB_DW-1:0] wd,
                          input int waits, input logic [`APB_DW-1:0] rd, input logic err,
                          input int hold, input int ncyc,
                          output int busy_n, output int done_n, output int pen_n,
                          output logic err_d, output logic [`APB_DW-1:0] rd_d,
                          output logic [`APB_SLAVES-1:0] psel_a, output logic pwrite_a,
                          output logic [`APB_AW-1:0] paddr_a);
    int acc;
    busy_n = 0; done_n = 0; pen_n = 0; acc = 0;
    err_d = 0; rd_d = '0; psel_a = '0; pwrite_a = 0; paddr_a = '0;
    @(negedge clk);
    addr = a; sel = s; we = w; re = r; wdata = wd; prdata = rd; pslverr = err; pready = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin done_n++; err_d = error; rd_d = read_data; end
      if (penable) begin
        pen_n++; acc++;
        if (acc == 1) begin psel_a = psel; pwrite_a = pwrite; paddr_a = paddr; end
      end
      pready = penable && (acc > waits);
      if (c + 1 >= hold) begin we = 0; re = 0; end
    end
    pready = 0;
  endtask

  int bn, dn, pn;
  logic ed, pw;
  logic [`APB_DW-1:0] rdd;
  logic [`APB_SLAVES-1:0] ps;
  logic [`APB_AW-1:0] pa;
  bit stuck;
  int guard;

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_psel", 64'(psel), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_rdata", 64'(read_data), 64'h0);
    rst = 0;

    run_xfer(32'h10, 2'b10, 1, 0, 32'hA5A5_A5A5, 0, 32'h0, 0, 1, 6,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("wr0_busy_cycles", 64'(bn), 64'd2);
    chk("wr0_done_count", 64'(dn), 64'd1);
    chk("wr0_penable_cycles", 64'(pn), 64'd1);
    chk("wr0_error", 64'(ed), 64'd0);
    chk("wr0_psel", 64'(ps), 64'h2);
    chk("wr0_pwrite", 64'(pw), 64'd1);
    chk("wr0_paddr", 64'(pa), 64'h10);
    chk("wr0_pwdata_idle", 64'(pwdata), 64'hA5A5_A5A5);

    run_xfer(32'h20, 2'b01, 0, 1, 32'h0, 3, 32'h1234_5678, 0, 1, 9,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("rd3_done_count", 64'(dn), 64'd1);
    chk("rd3_rdata", 64'(rdd), 64'h1234_5678);
    chk("rd3_penable_cycles", 64'(pn), 64'd4);
    chk("rd3_busy_cycles", 64'(bn), 64'd5);

    run_xfer(32'h30, 2'b01, 0, 1, 32'h0, 1000, 32'hDEAD_BEEF, 0, 1, 25,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("tmo_penable_cycles", 64'(pn), 64'd16);
    chk("tmo_done_count", 64'(dn), 64'd1);
    chk("tmo_error", 64'(ed), 64'd1);
    chk("tmo_rdata", 64'(rdd), 64'h0);

    run_xfer(32'h40, 2'b10, 1, 0, 32'h5555_0000, 0, 32'h0, 1, 1, 6,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("slverr_error", 64'(ed), 64'd1);
    chk("slverr_done_count", 64'(dn), 64'd1);

    run_xfer(32'h50, 2'b10, 0, 1, 32'h0, 0, 32'h0BAD_F00D, 0, 10, 14,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("hold_done_count", 64'(dn), 64'd1);
    chk("hold_rdata", 64'(rdd), 64'h0BAD_F00D);
    run_xfer(32'h54, 2'b10, 0, 1, 32'h0, 0, 32'h0000_CAFE, 0, 1, 6,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("rearm_done_count", 64'(dn), 64'd1);

    run_xfer(32'h60, 2'b11, 1, 0, 32'h1, 0, 32'h0, 0, 1, 6,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("sel11_psel", 64'(ps), 64'h1);

    run_xfer(32'h70, 2'b00, 1, 1, 32'h2, 0, 32'h0, 0, 3, 6,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("sel0_busy_cycles", 64'(bn), 64'd0);
    chk("sel0_done_count", 64'(dn), 64'd0);
    chk("sel0_penable_cycles", 64'(pn), 64'd0);

    run_xfer(32'h80, 2'b01, 1, 1, 32'h3, 0, 32'h7777_7777, 0, 1, 6,
             bn, dn, pn, ed, rdd, ps, pw, pa);
    chk("both_en_pwrite", 64'(pw), 64'd1);
    chk("both_en_rdata_held", 64'(rdd), 64'h0000_CAFE);

    // Reset during ACCESS.
    @(negedge clk);
    addr = 32'h90; sel = 2'b01; re = 1; pready = 0;
    guard = 0;
    while (!penable && guard < 10) begin @(negedge clk); re = 0; guard++; end
    chk("rst_reach_access", 64'(penable), 64'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_psel", 64'(psel), 64'h0);
    chk("rst_mid_penable", 64'(penable), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("rst_mid_done_after", 64'(done), 64'd0);

    stuck = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst     = ($urandom % 200) == 0;
      we      = ($urandom % 4) == 0;
      re      = ($urandom % 4) == 0;
      sel     = `APB_SLAVES'($urandom);
      addr    = $urandom;
      wdata   = $urandom;
      prdata  = $urandom;
      if (($urandom % 40) == 0) stuck = !stuck;
      pready  = stuck ? 1'b0 : (($urandom % 3) == 0);
      pslverr = ($urandom % 4) == 0;
    end
    @(negedge clk);
    rst = 0; we = 0; re = 0; pready = 0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max ACCESS cycles waiting for m_apb_pready_i before abort (range 1..255).
REQ-002 SHALL use one clock and a synchronous, active-high reset. Ports, clock and reset first:
- m_apb_pclk_i  in  1  clock
- m_apb_preset_i  in  1  synchronous reset, active-high
- read_write_addr_i  in  `APB_AW  request address
- read_write_sel_i  in  `APB_SLAVES  request device select
- write_en_i  in  1  write request, level
- write_data_i  in  `APB_DW  write data
- read_en_i  in  1  read request, level
- read_data_o  out  `APB_DW  read data, valid with done_o
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  completion status, valid with done_o
- m_apb_paddr_o  out  `APB_AW  PADDR
- m_apb_psel_o  out  `APB_SLAVES  PSELx, one-hot
- m_apb_penable_o  out  1  PENABLE
- m_apb_pwrite_o  out  1  PWRITE
- m_apb_pwdata_o  out  `APB_DW  PWDATA
- m_apb_prdata_i  in  `APB_DW  PRDATA, muxed from the selected slave
- m_apb_pready_i  in  1  PREADY
- m_apb_pslverr_i  in  1  PSLVERR

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ACCESS. All outputs SHALL be registered.
REQ-004 In IDLE, with armed=1, (write_en_i|read_en_i)=1 and read_write_sel_i!=0, the block SHALL accept the request at the clock edge and enter SETUP.
REQ-005 Acceptance SHALL latch addr, wdata and pwrite. pwrite=write_en_i, so write wins when both enables are high.
REQ-006 Acceptance SHALL latch psel as the lowest set bit of read_write_sel_i, so the output is always one-hot.
REQ-007 In IDLE, a request with read_write_sel_i==0 SHALL be ignored: no APB activity and no done_o.
REQ-008 In SETUP: psel=latched, penable=0, paddr/pwrite/pwdata stable. The FSM SHALL stay exactly 1 cycle, then go to ACCESS.
REQ-009 In ACCESS: psel held, penable=1. On a cycle sampling m_apb_pready_i=1 the FSM SHALL go to IDLE. Next cycle: psel=0, penable=0.
REQ-010 On that pready completion, next cycle done_o=1 for exactly 1 cycle and error_o=m_apb_pslverr_i. read_data_o=m_apb_prdata_i for a read; read_data_o holds its prior value for a write.
REQ-011 A wait counter SHALL reset to 0 on SETUP->ACCESS and increment each ACCESS cycle with pready=0.
REQ-012 When the counter reaches TIMEOUT_CYCLES with pready still 0, the block SHALL abort to IDLE. Next cycle: done_o=1, error_o=1, read_data_o=0, psel=0, penable=0.
REQ-013 Minimum transfer (pready=1 on first ACCESS cycle) SHALL be: accept edge, SETUP 1 cycle, ACCESS 1 cycle, done_o in the following cycle.
REQ-014 busy_o SHALL be 1 in SETUP and ACCESS and 0 in IDLE, including the done_o cycle.
REQ-015 Request enables and data SHALL be ignored while busy_o=1. Latched values SHALL stay stable for the whole transfer.
REQ-016 The armed flag SHALL clear on acceptance. It SHALL set again only after a cycle with write_en_i=0 and read_en_i=0, so a held level request gives exactly one transfer.
REQ-017 paddr, pwrite and pwdata SHALL hold their last values in IDLE. psel and penable SHALL be 0 in IDLE.
REQ-018 Outside ACCESS, m_apb_pready_i and m_apb_pslverr_i SHALL be ignored.

Reset
REQ-019 On a clock edge with m_apb_preset_i=1, the block SHALL set: state=IDLE, armed=1, counter=0.
REQ-020 The same reset SHALL clear all APB outputs, read_data_o, busy_o, done_o and error_o to 0.
REQ-021 A reset mid-transfer (SETUP or ACCESS) SHALL drop psel and penable the next cycle with no done_o pulse.

Verification
REQ-022 Write, zero wait: addr 0x0000_0010, sel 2'b10, wdata 0xA5A5_A5A5, pready=1 -> one SETUP, one ACCESS with psel 2'b10, pwrite 1; done_o pulse, error_o 0, busy_o 1 for 2 cycles.
REQ-023 Read, 3 wait states: pready low 3 ACCESS cycles, then high with prdata 0x1234_5678 -> done_o once, read_data_o 0x1234_5678, penable high 4 cycles.
REQ-024 Timeout and slave error:
- pready stuck 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles; done_o 1, error_o 1, read_data_o 0.
- Separate run, pslverr=1 with pready=1 -> error_o 1.
REQ-025 Level hold and select handling:
- read_en_i held high 10 cycles, pready=1 -> exactly one transfer.
- After enables drop for one cycle, the next request is accepted.
- sel 2'b11 -> psel 2'b01.
- sel 0 -> no activity.
REQ-026 Reset and simultaneous enables:
- m_apb_preset_i asserted in ACCESS -> psel/penable 0 the next cycle, no done_o.
- Both enables high at accept -> pwrite 1.
